// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external combinational ALU
// between two requesters. One operation in flight at a time: IDLE grants,
// EXEC captures the ALU result, RESP holds it until the owner takes it.
module alu_arbiter #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    // requester 0
    input  logic            req_valid_0,
    output logic            req_ready_0,
    input  logic [SIZE-1:0] req_a_0,
    input  logic [SIZE-1:0] req_b_0,
    input  logic [2:0]      req_func_0,
    output logic            rsp_valid_0,
    input  logic            rsp_ready_0,
    output logic [SIZE-1:0] rsp_data_0,
    output logic            rsp_zero_0,
    // requester 1
    input  logic            req_valid_1,
    output logic            req_ready_1,
    input  logic [SIZE-1:0] req_a_1,
    input  logic [SIZE-1:0] req_b_1,
    input  logic [2:0]      req_func_1,
    output logic            rsp_valid_1,
    input  logic            rsp_ready_1,
    output logic [SIZE-1:0] rsp_data_1,
    output logic            rsp_zero_1,
    // shared ALU
    output logic [SIZE-1:0] alu_a,
    output logic [SIZE-1:0] alu_b,
    output logic [2:0]      alu_func,
    input  logic [SIZE-1:0] alu_out,
    input  logic            alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            prio_q;
    logic            owner_q;
    logic [SIZE-1:0] a_q, b_q, res_q;
    logic [2:0]      func_q;
    logic            zero_q;

    logic            grant_sel_c;
    logic            accept_c;

    // Round-robin pick: a lone requester wins, a tie goes to the priority holder
    always_comb begin
        grant_sel_c = prio_q;
        if (req_valid_0 && req_valid_1) begin
            grant_sel_c = prio_q;
        end else if (req_valid_1) begin
            grant_sel_c = 1'b1;
        end else begin
            grant_sel_c = 1'b0;
        end
    end

    // Next-state and handshake outputs; everything is gated off while in reset
    always_comb begin
        state_d     = state_q;
        accept_c    = 1'b0;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        rsp_valid_0 = 1'b0;
        rsp_valid_1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n && (req_valid_0 || req_valid_1)) begin
                    accept_c    = 1'b1;
                    req_ready_0 = ~grant_sel_c;
                    req_ready_1 = grant_sel_c;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_0 = rst_n & ~owner_q;
                rsp_valid_1 = rst_n & owner_q;
                if (owner_q ? rsp_ready_1 : rsp_ready_0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, priority, operand latch and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            func_q  <= 3'd0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_c) begin
                owner_q <= grant_sel_c;
                prio_q  <= ~grant_sel_c;
                a_q     <= grant_sel_c ? req_a_1 : req_a_0;
                b_q     <= grant_sel_c ? req_b_1 : req_b_0;
                func_q  <= grant_sel_c ? req_func_1 : req_func_0;
            end
            if (state_q == EXEC) begin
                res_q  <= alu_out;
                zero_q <= alu_zero;
            end
        end
    end

    // Both requesters see the captured result; rsp_valid says whose it is
    assign rsp_data_0 = res_q;
    assign rsp_data_1 = res_q;
    assign rsp_zero_0 = zero_q;
    assign rsp_zero_1 = zero_q;

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_func = func_q;

endmodule
